// File: rtl/stripe_feeder.sv
`default_nettype none
// ============================================================================
// Module  : stripe_feeder
// Brief   : Walks reference B stripe by stripe, streams query A into the
//           64-PE Smith-Waterman array and keeps the global best score.
// Revision: 1.0 - initial release
// ============================================================================
module stripe_feeder #(
    parameter int SEQ_LEN   = 1024,
    parameter int PE_NUM    = 64,
    parameter int ADDR_W    = 10,
    parameter int STRIPE_W  = 4,
    parameter int SCORE_W   = 14,
    parameter int DRAIN_MAX = 136
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_go,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_a_ren,
    output logic [ADDR_W-1:0]     o_a_addr,
    input  logic [1:0]            i_a_data,
    output logic                  o_b_ren,
    output logic [STRIPE_W-1:0]   o_b_addr,
    input  logic [2*PE_NUM-1:0]   i_b_data,
    output logic                  o_pe_start,
    output logic [1:0]            o_pe_A,
    output logic [2*PE_NUM-1:0]   o_pe_B,
    input  logic                  i_stripe_end,
    input  logic [ADDR_W-1:0]     i_start_position,
    input  logic [ADDR_W-1:0]     i_end_position,
    input  logic [SCORE_W-1:0]    i_max_score_stripe,
    output logic [SCORE_W-1:0]    o_max_score,
    output logic [STRIPE_W-1:0]   o_max_stripe,
    output logic [ADDR_W:0]       o_max_end_pos
);

    localparam int                  c_CNT_W       = $clog2(DRAIN_MAX + 2);
    localparam logic [ADDR_W-1:0]   c_LAST_ADDR   = ADDR_W'(SEQ_LEN - 1);
    localparam logic [STRIPE_W-1:0] c_LAST_STRIPE = STRIPE_W'(SEQ_LEN / PE_NUM - 1);
    localparam logic [c_CNT_W-1:0]  c_DRAIN_MAX   = c_CNT_W'(DRAIN_MAX);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LATCH_B = 3'd2,
        S_FEED    = 3'd3,
        S_DRAIN   = 3'd4,
        S_NEXT    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [ADDR_W-1:0]      r_base_pos, r_a_ptr, r_start_pos, r_end_pos;
    logic [STRIPE_W-1:0]    r_stripe, r_max_stripe;
    logic [SCORE_W-1:0]     r_stripe_score, r_max_score;
    logic [ADDR_W:0]        r_max_end_pos;
    logic [c_CNT_W-1:0]     r_drain_cnt;
    logic                   r_ren_d, r_pe_start, r_err;
    logic [1:0]             r_pe_a;
    logic [2*PE_NUM-1:0]    r_pe_b;

    logic                   w_a_ren, w_b_ren, w_done, w_end_take, w_timeout, w_fwd;
    logic [ADDR_W:0]        w_base_sum, w_end_abs;
    logic [ADDR_W-1:0]      w_base_clamp;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_ren     = 1'b0;
        w_b_ren     = 1'b0;
        w_done      = 1'b0;
        w_end_take  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE:    if (i_go) w_state_nxt = S_LOAD_B;
            S_LOAD_B: begin
                w_b_ren     = 1'b1;
                w_state_nxt = S_LATCH_B;
            end
            S_LATCH_B: w_state_nxt = S_FEED;
            S_FEED: begin
                w_a_ren = 1'b1;
                if (i_stripe_end) begin
                    w_end_take  = 1'b1;
                    w_state_nxt = S_NEXT;
                end else if (r_a_ptr == c_LAST_ADDR) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A stripe_end arriving on the timeout cycle takes priority.
                if (i_stripe_end) begin
                    w_end_take  = 1'b1;
                    w_state_nxt = S_NEXT;
                end else if (r_drain_cnt == c_DRAIN_MAX) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT:    w_state_nxt = (r_stripe == c_LAST_STRIPE) ? S_DONE : S_LOAD_B;
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    assign w_fwd        = r_ren_d & ~w_end_take;
    assign w_base_sum   = {1'b0, r_base_pos} + {1'b0, r_start_pos};
    assign w_base_clamp = (w_base_sum > {1'b0, c_LAST_ADDR}) ? c_LAST_ADDR : w_base_sum[ADDR_W-1:0];
    assign w_end_abs    = {1'b0, r_base_pos} + {1'b0, r_end_pos};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base_pos     <= '0;
            r_a_ptr        <= '0;
            r_start_pos    <= '0;
            r_end_pos      <= '0;
            r_stripe       <= '0;
            r_stripe_score <= '0;
            r_max_stripe   <= '0;
            r_max_score    <= '0;
            r_max_end_pos  <= '0;
            r_drain_cnt    <= '0;
            r_ren_d        <= 1'b0;
            r_pe_start     <= 1'b0;
            r_pe_a         <= '0;
            r_pe_b         <= '0;
            r_err          <= 1'b0;
        end else begin
            // Read data lands one cycle after the enable; a taken stripe_end
            // discards whatever is still in flight.
            r_ren_d     <= w_a_ren & ~w_end_take;
            r_pe_start  <= w_fwd;
            r_pe_a      <= w_fwd ? i_a_data : 2'b00;
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + c_CNT_W'(1) : '0;

            if (r_state == S_IDLE && i_go) begin
                r_max_score   <= '0;
                r_max_stripe  <= '0;
                r_max_end_pos <= '0;
                r_err         <= 1'b0;
                r_base_pos    <= '0;
                r_stripe      <= '0;
            end
            if (r_state == S_LATCH_B) begin
                r_pe_b  <= i_b_data;
                r_a_ptr <= r_base_pos;
            end
            if (r_state == S_FEED && !i_stripe_end && r_a_ptr != c_LAST_ADDR)
                r_a_ptr <= r_a_ptr + ADDR_W'(1);
            if (w_end_take) begin
                r_start_pos    <= i_start_position;
                r_end_pos      <= i_end_position;
                r_stripe_score <= i_max_score_stripe;
            end
            if (w_timeout) begin
                r_err          <= 1'b1;
                r_start_pos    <= '0;
                r_stripe_score <= '0;
            end
            if (r_state == S_NEXT) begin
                r_base_pos <= w_base_clamp;
                if (r_stripe_score > r_max_score) begin
                    r_max_score   <= r_stripe_score;
                    r_max_stripe  <= r_stripe;
                    r_max_end_pos <= w_end_abs;
                end
                if (r_stripe != c_LAST_STRIPE)
                    r_stripe <= r_stripe + STRIPE_W'(1);
            end
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = w_done;
    assign o_err         = r_err;
    assign o_a_ren       = w_a_ren;
    assign o_a_addr      = w_a_ren ? r_a_ptr : '0;
    assign o_b_ren       = w_b_ren;
    assign o_b_addr      = r_stripe;
    assign o_pe_start    = r_pe_start;
    assign o_pe_A        = r_pe_a;
    assign o_pe_B        = r_pe_b;
    assign o_max_score   = r_max_score;
    assign o_max_stripe  = r_max_stripe;
    assign o_max_end_pos = r_max_end_pos;

endmodule
`default_nettype wire
